// File: rtl/bmp_stream_writer_if.sv
// Pixel-in / byte-out stream bundle for the BMP writer.
// master = writer side, slave = environment side.
interface bmp_stream_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_R;
  logic [7:0]  in_G;
  logic [7:0]  in_B;
  logic [10:0] in_X;
  logic [10:0] in_Y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_sof;
  logic        out_eof;
  logic        frame_done;
  logic        err_seq;

  modport master (
    input  in_valid, in_R, in_G, in_B, in_X, in_Y,
    input  out_ready,
    output in_ready,
    output out_valid, out_byte, out_sof, out_eof,
    output frame_done, err_seq
  );

  modport slave (
    output in_valid, in_R, in_G, in_B, in_X, in_Y,
    output out_ready,
    input  in_ready,
    input  out_valid, out_byte, out_sof, out_eof,
    input  frame_done, err_seq
  );
endinterface

// File: rtl/bmp_stream_writer.sv
// Serialises a raster RGB pixel stream into a top-down 24-bit BMP byte stream.
// Header from a constant table, then B,G,R per pixel and zero row padding.
module bmp_stream_writer #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int BMP_HEADER_NUM = 54,
  parameter int PPM            = 2835
) (
  input  logic               CAMERA_CLK,
  input  logic               rst,
  bmp_stream_writer_if.master bus
);

  localparam int STRIDE = ((WIDTH * 3 + 3) / 4) * 4;
  localparam int PAD    = STRIDE - WIDTH * 3;
  localparam int IMG    = STRIDE * HEIGHT;
  localparam int FSIZE  = BMP_HEADER_NUM + IMG;

  // Byte 0 sits in the LSBs, so 32-bit fields land little-endian.
  localparam logic [8*54-1:0] HDR = {
    32'd0, 32'd0,
    32'(PPM), 32'(PPM),
    32'(IMG), 32'd0,
    16'd24, 16'd1,
    32'(-HEIGHT), 32'(WIDTH),
    32'd40, 32'(BMP_HEADER_NUM),
    32'd0, 32'(FSIZE),
    8'h4D, 8'h42
  };

  localparam logic [5:0]  HDR_LAST = 6'(BMP_HEADER_NUM - 1);
  localparam logic [1:0]  PAD_LAST = 2'((PAD > 0) ? PAD - 1 : 0);
  localparam logic [10:0] X_LAST   = 11'(WIDTH - 1);
  localparam logic [10:0] Y_LAST   = 11'(HEIGHT - 1);
  localparam bit          HAS_PAD  = (PAD > 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_PB   = 3'd3;
  localparam logic [2:0] S_PG   = 3'd4;
  localparam logic [2:0] S_PR   = 3'd5;
  localparam logic [2:0] S_PAD  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [10:0] ex_q, ex_d;
  logic [10:0] ey_q, ey_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  g_q, g_d;
  logic [7:0]  b_q, b_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_byte_q, out_byte_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;
  logic        frame_done_q, frame_done_d;
  logic        err_q, err_d;
  logic        in_ready_c;
  logic        hs;
  logic        origin;
  logic        row_end;
  logic        last_px;
  logic [5:0]  nidx;

  assign hs      = out_valid_q && bus.out_ready;
  assign origin  = (bus.in_X == 11'd0) && (bus.in_Y == 11'd0);
  assign last_px = (ex_q == X_LAST) && (ey_q == Y_LAST);
  assign nidx    = idx_q + 6'd1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ex_d         = ex_q;
    ey_d         = ey_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    out_valid_d  = out_valid_q;
    out_byte_d   = out_byte_q;
    out_sof_d    = out_sof_q;
    out_eof_d    = out_eof_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    in_ready_c   = 1'b0;
    row_end      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Origin pixel stays pending; it is consumed in LOAD.
        in_ready_c = !(bus.in_valid && origin);
        if (bus.in_valid && origin) begin
          state_d     = S_HDR;
          idx_d       = 6'd0;
          ex_d        = 11'd0;
          ey_d        = 11'd0;
          out_valid_d = 1'b1;
          out_byte_d  = HDR[7:0];
          out_sof_d   = 1'b1;
          out_eof_d   = 1'b0;
        end
      end
      S_HDR: begin
        if (hs) begin
          out_sof_d = 1'b0;
          if (idx_q == HDR_LAST) begin
            state_d     = S_LOAD;
            out_valid_d = 1'b0;
          end else begin
            idx_d      = nidx;
            out_byte_d = HDR[{nidx, 3'b000} +: 8];
          end
        end
      end
      S_LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          r_d         = bus.in_R;
          g_d         = bus.in_G;
          b_d         = bus.in_B;
          err_d       = (bus.in_X != ex_q) || (bus.in_Y != ey_q);
          state_d     = S_PB;
          out_valid_d = 1'b1;
          out_byte_d  = bus.in_B;
          out_eof_d   = 1'b0;
        end
      end
      S_PB: begin
        if (hs) begin
          state_d    = S_PG;
          out_byte_d = g_q;
        end
      end
      S_PG: begin
        if (hs) begin
          state_d    = S_PR;
          out_byte_d = r_q;
          out_eof_d  = last_px && !HAS_PAD;
        end
      end
      S_PR: begin
        if (hs) begin
          if (ex_q != X_LAST) begin
            ex_d        = ex_q + 11'd1;
            state_d     = S_LOAD;
            out_valid_d = 1'b0;
          end else if (HAS_PAD) begin
            state_d    = S_PAD;
            idx_d      = 6'd0;
            out_byte_d = 8'h00;
            out_eof_d  = (ey_q == Y_LAST) && (PAD_LAST == 2'd0);
          end else begin
            row_end = 1'b1;
          end
        end
      end
      S_PAD: begin
        if (hs) begin
          if (idx_q[1:0] == PAD_LAST) begin
            row_end = 1'b1;
          end else begin
            idx_d     = nidx;
            out_eof_d = (ey_q == Y_LAST) &&
                        (idx_q[1:0] + 2'd1 == PAD_LAST);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (row_end) begin
      ex_d        = 11'd0;
      out_valid_d = 1'b0;
      out_eof_d   = 1'b0;
      if (ey_q != Y_LAST) begin
        ey_d    = ey_q + 11'd1;
        state_d = S_LOAD;
      end else begin
        state_d      = S_IDLE;
        frame_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 6'd0;
      ex_q         <= 11'd0;
      ey_q         <= 11'd0;
      r_q          <= 8'd0;
      g_q          <= 8'd0;
      b_q          <= 8'd0;
      out_valid_q  <= 1'b0;
      out_byte_q   <= 8'd0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ex_q         <= ex_d;
      ey_q         <= ey_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      out_valid_q  <= out_valid_d;
      out_byte_q   <= out_byte_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_byte   = out_byte_q;
  assign bus.out_sof    = out_sof_q;
  assign bus.out_eof    = out_eof_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err_seq    = err_q;

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Directed/randomised bench for bmp_stream_writer on a 3x2 image.
// Expected file bytes come from a BMP layout model built from plain arithmetic.
module tb_bmp_stream_writer;

  localparam int W      = 3;
  localparam int H      = 2;
  localparam int PPMV   = 2835;
  localparam int STRIDE = ((W * 3 + 3) / 4) * 4;
  localparam int PADN   = STRIDE - W * 3;
  localparam int IMG    = STRIDE * H;
  localparam int FSIZE  = 54 + IMG;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bmp_stream_writer_if bus();

  bmp_stream_writer #(
    .WIDTH(W),
    .HEIGHT(H),
    .BMP_HEADER_NUM(54),
    .PPM(PPMV)
  ) dut (
    .CAMERA_CLK(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] cap_b[$];
  logic       cap_s[$];
  logic       cap_e[$];
  logic [7:0] exp_q[$];
  int sof_cyc = 0;
  int eof_cyc = 0;
  int fd_cyc = 0;
  int fd_cnt = 0;
  int err_cnt = 0;
  int stall_bad = 0;
  bit rand_rdy = 0;

  logic [7:0] px_r[H][W];
  logic [7:0] px_g[H][W];
  logic [7:0] px_b[H][W];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    bus.out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Collector: handshakes, hold-while-stalled, pulses.
  initial begin
    logic pv, ps, pe;
    logic [7:0] pbyte;
    pv = 0; ps = 0; pe = 0; pbyte = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
      end else begin
        if (pv && !(bus.out_valid && bus.out_byte == pbyte &&
                    bus.out_sof == ps && bus.out_eof == pe))
          stall_bad++;
        pv    = bus.out_valid && !bus.out_ready;
        pbyte = bus.out_byte;
        ps    = bus.out_sof;
        pe    = bus.out_eof;
        if (bus.out_valid && bus.out_ready) begin
          cap_b.push_back(bus.out_byte);
          cap_s.push_back(bus.out_sof);
          cap_e.push_back(bus.out_eof);
          if (bus.out_sof) sof_cyc = cyc;
          if (bus.out_eof) eof_cyc = cyc;
        end
        if (bus.frame_done) begin
          fd_cnt++;
          fd_cyc = cyc;
        end
        if (bus.err_seq) err_cnt++;
      end
    end
  end

  task automatic push32(input logic [31:0] v);
    for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic push16(input logic [15:0] v);
    exp_q.push_back(v[7:0]);
    exp_q.push_back(v[15:8]);
  endtask

  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h4D);
    push32(FSIZE);
    push32(0);
    push32(54);
    push32(40);
    push32(W);
    push32(-H);
    push16(1);
    push16(24);
    push32(0);
    push32(IMG);
    push32(PPMV);
    push32(PPMV);
    push32(0);
    push32(0);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        exp_q.push_back(px_b[y][x]);
        exp_q.push_back(px_g[y][x]);
        exp_q.push_back(px_r[y][x]);
      end
      for (int p = 0; p < PADN; p++) exp_q.push_back(8'h00);
    end
  endtask

  task automatic clear_cap();
    cap_b.delete();
    cap_s.delete();
    cap_e.delete();
  endtask

  task automatic fill_random();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        px_r[y][x] = 8'($urandom);
        px_g[y][x] = 8'($urandom);
        px_b[y][x] = 8'($urandom);
      end
  endtask

  task automatic send(input int x, input int y, input logic [7:0] r,
                      input logic [7:0] g, input logic [7:0] b);
    int n;
    logic rd;
    n = 0;
    bus.in_X = 11'(x);
    bus.in_Y = 11'(y);
    bus.in_R = r;
    bus.in_G = g;
    bus.in_B = b;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      rd = bus.in_ready;
      @(posedge clk);
      #1;
      if (rd) break;
      n++;
      if (n > 500) begin
        tests++;
        fails++;
        $error("FAIL send_timeout observed=stuck expected=accept x=%0d y=%0d", x, y);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_pixels(input int bad, input int count);
    for (int k = 0; k < count; k++) begin
      if (k == bad)
        send(1, 0, px_r[k/W][k%W], px_g[k/W][k%W], px_b[k/W][k%W]);
      else
        send(k % W, k / W, px_r[k/W][k%W], px_g[k/W][k%W], px_b[k/W][k%W]);
    end
  endtask

  task automatic run_frame(input int bad);
    int fd0, n;
    fd0 = fd_cnt;
    send_pixels(bad, W * H);
    n = 0;
    while (fd_cnt == fd0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("frame_done_seen", 32'(fd_cnt - fd0), 32'd1);
  endtask

  task automatic compare_frame(input string tag);
    int ns, ne, m;
    check({tag, "_len"}, cap_b.size(), FSIZE);
    m = (cap_b.size() < exp_q.size()) ? cap_b.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_byte%0d", tag, i), cap_b[i], exp_q[i]);
    ns = 0;
    ne = 0;
    for (int i = 0; i < cap_s.size(); i++) begin
      ns += int'(cap_s[i]);
      ne += int'(cap_e[i]);
    end
    check({tag, "_sof_cnt"}, ns, 1);
    check({tag, "_eof_cnt"}, ne, 1);
    if (m > 0) begin
      check({tag, "_sof_first"}, cap_s[0], 1);
      check({tag, "_eof_last"}, cap_e[cap_e.size()-1], 1);
    end
    check({tag, "_fd_after_eof"}, fd_cyc - eof_cyc, 1);
  endtask

  initial begin
    int e0, fd0;
    bus.in_valid = 0;
    bus.in_R = 0;
    bus.in_G = 0;
    bus.in_B = 0;
    bus.in_X = 0;
    bus.in_Y = 0;
    bus.out_ready = 1;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_byte", bus.out_byte, 0);
    check("rst_out_sof", bus.out_sof, 0);
    check("rst_out_eof", bus.out_eof, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_err_seq", bus.err_seq, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Non-origin pixels ahead of the frame are dropped silently.
    clear_cap();
    send(2, 1, 8'h11, 8'h22, 8'h33);
    send(1, 0, 8'h44, 8'h55, 8'h66);
    repeat (3) @(posedge clk);
    #1;
    check("resync_no_bytes", cap_b.size(), 0);

    // Frame 1: test-plan pattern, out_ready held high.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        px_r[y][x] = 8'(8'h10 + x);
        px_g[y][x] = 8'(8'h20 + y);
        px_b[y][x] = 8'h30;
      end
    build_exp();
    clear_cap();
    e0 = err_cnt;
    run_frame(-1);
    compare_frame("f1");
    check("f1_fsize_b2", {cap_b[5], cap_b[4], cap_b[3], cap_b[2]}, 32'h0000004E);
    check("f1_negh", {cap_b[25], cap_b[24], cap_b[23], cap_b[22]}, 32'hFFFFFFFE);
    check("f1_img", {cap_b[37], cap_b[36], cap_b[35], cap_b[34]}, 32'h00000018);
    check("f1_row0_first", {cap_b[54], cap_b[55], cap_b[56]}, 32'h00302010);
    check("f1_row0_pad", {cap_b[63], cap_b[64], cap_b[65]}, 32'h0);
    check("f1_eof_idx77", cap_e[77], 1);
    check("f1_cycles_sof_to_eof", eof_cyc - sof_cyc, 83);
    check("f1_no_err", err_cnt - e0, 0);

    // Frame 2: random pixels, random back-pressure.
    rand_rdy = 1;
    fill_random();
    build_exp();
    clear_cap();
    e0 = err_cnt;
    run_frame(-1);
    compare_frame("f2");
    check("f2_no_err", err_cnt - e0, 0);
    check("f2_stall_hold", stall_bad, 0);

    // Frame 3: coordinate (1,0) where (2,0) is due.
    fill_random();
    build_exp();
    clear_cap();
    e0 = err_cnt;
    run_frame(2);
    compare_frame("f3");
    check("f3_err_once", err_cnt - e0, 1);
    check("f3_stall_hold", stall_bad, 0);
    rand_rdy = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset inside row 1 aborts the frame.
    fill_random();
    clear_cap();
    fd0 = fd_cnt;
    send_pixels(-1, W + 1);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_byte", bus.out_byte, 0);
    check("midrst_out_sof", bus.out_sof, 0);
    check("midrst_out_eof", bus.out_eof, 0);
    check("midrst_err_seq", bus.err_seq, 0);
    check("midrst_frame_done", bus.frame_done, 0);
    rst = 0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_fd", fd_cnt - fd0, 0);

    // Restart after the abort.
    fill_random();
    build_exp();
    clear_cap();
    run_frame(-1);
    compare_frame("f4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bmp_stream_writer.md
# bmp_stream_writer

Sink-side counterpart of the simulated camera pixel source: accepts the raster-order RGB pixel stream (R, G, B plus X/Y coordinates) and serialises it into a byte stream forming a complete 24-bit BMP file. Output is a 54-byte header, then pixel bytes in B,G,R order with zero row padding. Sits at the end of the image-processing chain and feeds the file dump or host link. Uses top-down BMP (negative height), so no frame buffer is needed.

## Interface
- WIDTH, 768, image width in pixels
- HEIGHT, 512, image height in pixels
- BMP_HEADER_NUM, 54, header length in bytes (fixed; not to be overridden)
- PPM, 2835, horizontal/vertical pixels-per-metre header field
- CAMERA_CLK  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  pixel present on in_R/G/B/X/Y
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_R, in_G, in_B  in  8 each  pixel colour
- in_X, in_Y  in  11 each  pixel coordinates
- out_valid  out  1  out_byte valid
- out_ready  in  1  downstream accepts byte when out_valid && out_ready
- out_byte  out  8  BMP file byte
- out_sof  out  1  high with first header byte ('B')
- out_eof  out  1  high with last byte of file
- frame_done  out  1  one-cycle pulse after the last byte is accepted
- err_seq  out  1  one-cycle pulse on a coordinate mismatch

## Operation
- Constants: STRIDE = ceil(WIDTH*3/4)*4; PAD = STRIDE - WIDTH*3 (0..3); IMG = STRIDE*HEIGHT; FSIZE = 54 + IMG.
- Header, little-endian multi-byte fields, in order:
  - 'B','M' (0x42,0x4D)
  - FSIZE (4)
  - 0 (4)
  - offset 54 (4)
  - DIB size 40 (4)
  - WIDTH (4)
  - two's-complement -HEIGHT (4)
  - planes 1 (2)
  - bpp 24 (2)
  - compression 0 (4)
  - IMG (4)
  - PPM (4)
  - PPM (4)
  - 0 (4)
  - 0 (4)
- States:
  - IDLE: in_ready=1 unless in_valid && X==0 && Y==0. Non-origin pixels are consumed and discarded (resync). An origin pixel is left pending and moves the FSM to HEADER.
  - HEADER: emits bytes 0..53 via an index counter. After byte 53 is accepted, go to LOAD.
  - LOAD: in_ready=1, out_valid=0. On accept, latch RGB and compare X/Y against the expected counters (ex, ey), then go to PB.
  - PB, PG, PR: emit B, G, R. After PR is accepted:
    - ex<WIDTH-1: ex++, go to LOAD.
    - Otherwise, if PAD>0: go to PAD.
    - Otherwise: end of row.
  - PAD: emits PAD bytes of 0x00, then end of row.
  - End of row: ex=0. If ey<HEIGHT-1, ey++ and go to LOAD; else the file is complete and the FSM goes to IDLE.
- Mismatch: if latched X!=ex or Y!=ey, pulse err_seq the cycle after acceptance. The pixel is still written at the expected position and counters advance normally, so file length is always FSIZE.
- Byte budget: exactly FSIZE bytes per frame. out_eof marks the final byte (last PAD byte if PAD>0, else last R).
- in_ready is 0 in HEADER, PB, PG, PR and PAD.

## Timing
- Reset values: state IDLE; ex=ey=0; header index 0; out_valid, out_byte, out_sof, out_eof, frame_done, err_seq and the pixel latch all 0. in_ready=1 in IDLE after reset.
- Reset asserted mid-frame aborts the frame with no eof or frame_done. The next cycle after reset release is IDLE.
- Output handshake: while out_valid && !out_ready, out_byte, out_sof and out_eof hold stable. out_valid never drops without a handshake, except on rst.
- HEADER is entered the cycle after the origin pixel is seen in IDLE. The first header byte is valid that cycle.
- Throughput with out_ready=1: 4 cycles per pixel (LOAD, PB, PG, PR) plus PAD cycles per row. Header takes 54 cycles.
- frame_done pulses the cycle after the eof handshake, coinciding with the return to IDLE.
- err_seq pulses in the PB entry cycle. Pulses from consecutive pixels must not merge into one: they are separated by at least 3 cycles.
- Back-to-back frames: an origin pixel already waiting in IDLE starts HEADER with no extra idle cycle.

## Test plan
- WIDTH=3, HEIGHT=2, out_ready=1, pixels (x,y) with R=0x10+x, G=0x20+y, B=0x30 -> 78 bytes total.
  - Header bytes 2..5 = 4E 00 00 00; bytes 22..25 = FE FF FF FF; bytes 34..37 = 18 00 00 00.
  - Row 0 = 30 20 10 30 20 11 30 20 12 00 00 00.
  - out_eof on byte 77, frame_done one cycle later.
- Default 768x512 -> FSIZE 1179702 (0x00120036), PAD=0, eof on the final R byte, no err_seq.
- out_ready toggled pseudo-randomly -> byte sequence identical to the out_ready=1 run; no byte changes while stalled.
- Stream starting at (2,1) before (0,0) -> the non-origin pixels are discarded with no output, and the header starts only on the origin pixel.
- Pixel (1,0) sent where (2,0) is expected -> err_seq pulse once, file length still FSIZE.
- rst asserted during row 1 -> all outputs 0 next cycle, no frame_done. The next origin pixel restarts the header from 'B' with out_sof=1.
